// File: rtl/shared_reg_arb_pkg.sv
// Shared types and defaults for the shared-register write arbiter.
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_N_DEF = 4;
  localparam int unsigned ARB_W_DEF = 8;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_store.sv
// Enable-gated W-bit register with asynchronous active-high reset.
// q_n is derived from the same flops so it can never disagree with q.
module shared_reg_store #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_n
);

  logic [W-1:0] data_q;

  // Load d when enabled; clear immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q   = data_q;
  assign q_n = ~data_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register.
// Each write runs IDLE -> WRITE -> ACK and returns a one-hot ack.
// Optional: define ARB_LOCK_EN to add a per-requester lock input that
// holds the round-robin pointer on the locked winner.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int unsigned N = ARB_N_DEF,
  parameter int unsigned W = ARB_W_DEF,
  localparam int unsigned GW = arb_idx_w(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   ack,
  output logic [GW-1:0]  gnt_id,
  output logic           busy,
  output logic [W-1:0]   q,
  output logic [W-1:0]   q_n
);

  arb_state_t    state_q;
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] gnt_id_q;
  logic [N-1:0]  ack_q;
  logic          busy_q;
  logic [W-1:0]  cap_q;

  logic          win_found;
  logic [GW-1:0] win_id;
  logic [W-1:0]  win_data;
  logic [GW-1:0] ptr_d;

  // First asserted request scanning upward from ptr, wrapping by compare.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!win_found && req[GW'(idx)]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
        win_data  = wdata[idx*W +: W];
      end
    end
  end

  // Pointer moves one past the winner unless the winner holds its lock.
  always_comb begin
    ptr_d = (gnt_id_q == GW'(N - 1)) ? '0 : gnt_id_q + GW'(1);
`ifdef ARB_LOCK_EN
    if (lock[gnt_id_q]) begin
      ptr_d = gnt_id_q;
    end
`endif
  end

  // Write sequencer with registered ack/busy/gnt_id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      cap_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (win_found) begin
            gnt_id_q <= win_id;
            cap_q    <= win_data;
            busy_q   <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          ack_q   <= N'(1) << gnt_id_q;
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  shared_reg_store #(
    .W (W)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == WRITE),
    .d     (cap_q),
    .q     (q),
    .q_n   (q_n)
  );

  assign ack    = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (N=4, W=8).
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  q_n;

  always #5 clk = ~clk;

  shared_reg_arbiter #(
    .N (4),
    .W (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .ack    (ack),
    .gnt_id (gnt_id),
    .busy   (busy),
    .q      (q),
    .q_n    (q_n)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  lk;
    logic        drop;
    logic [1:0]  id;
    logic [7:0]  q;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] id;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops one expected write.
  exp_t       mon_e;
  logic [7:0] mon_qn;
  always @(negedge clk) begin
    if (!reset && ack !== 4'b0000) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        mon_e  = sb.pop_front();
        mon_qn = ~mon_e.q;
        chk("ack", 32'(ack), 32'(mon_e.ack));
        chk("gnt_id", 32'(gnt_id), 32'(mon_e.id));
        chk("q", 32'(q), 32'(mon_e.q));
        chk("q_n", 32'(q_n), 32'(mon_qn));
      end
    end
  end

  // Present one request pattern, expect one completed write.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   start;
    int   n;
    req   = v.req;
    wdata = v.wdata;
`ifdef ARB_LOCK_EN
    lock  = v.lk;
`endif
    e.ack = 4'b0001 << v.id;
    e.id  = v.id;
    e.q   = v.q;
    sb.push_back(e);
    start = ack_cnt;
    n     = 0;
    while (ack_cnt == start && n < 8) begin
      @(negedge clk);
      #1;
      n++;
      if (n <= 3) chk({tag, "_busy"}, 32'(busy), (n >= 2) ? 32'h1 : 32'h0);
      if (n == 2) begin
        wdata = ~wdata;
        if (v.drop) req = 4'b0000;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    if (ack_cnt == start) sb.delete();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[10];
`ifdef ARB_LOCK_EN
  vec_t lv[4];
`endif
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 2'd0, 8'h10};
    vt[1] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 2'd1, 8'h11};
    vt[2] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 2'd2, 8'h12};
    vt[3] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 2'd3, 8'h13};
    vt[4] = '{4'b1111, 32'h13121110, 4'b0000, 1'b0, 2'd0, 8'h10};
    vt[5] = '{4'b0100, 32'h00A50000, 4'b0000, 1'b1, 2'd2, 8'hA5};
    vt[6] = '{4'b0011, 32'h0000B7C4, 4'b0000, 1'b1, 2'd0, 8'hC4};
    vt[7] = '{4'b0011, 32'h0000B7C4, 4'b0000, 1'b1, 2'd1, 8'hB7};
    vt[8] = '{4'b1000, 32'h9E000000, 4'b0000, 1'b1, 2'd3, 8'h9E};
    vt[9] = '{4'b0110, 32'h00665500, 4'b0000, 1'b1, 2'd1, 8'h55};
`ifdef ARB_LOCK_EN
    lv[0] = '{4'b1010, 32'h43002100, 4'b0010, 1'b0, 2'd1, 8'h21};
    lv[1] = '{4'b1010, 32'h43002100, 4'b0010, 1'b0, 2'd1, 8'h21};
    lv[2] = '{4'b1010, 32'h43002100, 4'b0000, 1'b0, 2'd1, 8'h21};
    lv[3] = '{4'b1010, 32'h43002100, 4'b0000, 1'b1, 2'd3, 8'h43};
    lock  = 4'b0000;
`endif

    // Reset, then idle.
    reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;
    #1;
    chk("reset_state", {27'h0, ack, busy}, 32'h0);
    chk("reset_q", {16'h0, q, q_n}, 32'h000000FF);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), {11'h0, ack, busy, q, q_n}, 32'h000000FF);
    end
    @(posedge clk);
    #1;

    // Table: round-robin, single write, wrap/skip.
    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of a write of 0x3C.
    req   = 4'b0001;
    wdata = 32'h0000003C;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_reset_q", {16'h0, q, q_n}, 32'h000000FF);
    chk("mid_reset_ctl", {25'h0, ack, busy, gnt_id}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", {20'h0, ack, busy, q}, 32'h0);
    reset = 1'b0;
    rv = '{4'b0001, 32'h0000003C, 4'b0000, 1'b1, 2'd0, 8'h3C};
    run_vec(rv, "post_reset");

`ifdef ARB_LOCK_EN
    for (int i = 0; i < 4; i++) begin
      run_vec(lv[i], $sformatf("lock%0d", i));
    end
    lock = 4'b0000;
`endif

    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
